jt6295_romcache: RTL and testbench

Byte-wide ROM front end for the jt6295 ADPCM core: it answers the core's `rom_addr`/`rom_data`/`rom_ok` port from a small fully associative cache of 32-bit words. Misses are filled from a shared 32-bit SDRAM port through a req/ack/dok handshake. It sits directly upstream of jt6295's ROM interface and downstream of the SDRAM arbiter.

---
 rtl/jt6295_romcache_if.sv | 19 +
 rtl/jt6295_romcache.sv | 107 ++++++++++
 tb/tb_jt6295_romcache.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_romcache_if.sv
// jt6295_romcache_if: jt6295 ROM port plus SDRAM fetch port seen by the ROM cache
interface jt6295_romcache_if;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [15:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dok;
  logic [31:0] sdram_data;
  modport master (
    output rom_addr, sdram_ack, sdram_dok, sdram_data,
    input  rom_data, rom_ok, sdram_addr, sdram_req
  );
  modport slave (
    input  rom_addr, sdram_ack, sdram_dok, sdram_data,
    output rom_data, rom_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jt6295_romcache.sv
// jt6295_romcache: fully associative word cache feeding jt6295 ROM bytes; JT6295_PREFETCH_EN adds next-word prefetch
module jt6295_romcache #(
  parameter int LINES = 4
) (
  input logic             clk,
  input logic             rst_n,
  jt6295_romcache_if.slave bus
);
  localparam int VW = $clog2(LINES);
`ifdef JT6295_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
`endif
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [15:0] tag [LINES];
  logic [31:0] line [LINES];
  logic [VW-1:0] victim;
  logic [31:0] fill_data;
  logic [15:0] word_addr;
  logic [17:0] last_addr;
  logic [7:0] data_q;
  logic hit_q, hit, capture;
  logic [31:0] hit_word;
`ifdef JT6295_PREFETCH_EN
  logic pf, pf_hit;
  // next-word lookup used to skip prefetches of words already cached
  always_comb begin
    pf_hit = 1'b0;
    for (int i = 0; i < LINES; i++)
      if (valid[i] && tag[i] == word_addr + 16'd1) pf_hit = 1'b1;
  end
`endif
  // parallel tag compare against the current byte address
  always_comb begin
    hit = 1'b0;
    hit_word = '0;
    for (int i = 0; i < LINES; i++)
      if (valid[i] && tag[i] == bus.rom_addr[17:2]) begin
        hit = 1'b1;
        hit_word = line[i];
      end
  end
  assign capture = (state == REQ && bus.sdram_ack && bus.sdram_dok) || (state == WAIT && bus.sdram_dok);
  // next-state logic; a started fetch always runs to FILL
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!hit) state_nx = REQ;
      REQ:  if (bus.sdram_ack) state_nx = bus.sdram_dok ? FILL : WAIT;
      WAIT: if (bus.sdram_dok) state_nx = FILL;
`ifdef JT6295_PREFETCH_EN
      FILL: state_nx = pf ? IDLE : PREFETCH;
      PREFETCH: state_nx = pf_hit ? IDLE : REQ;
`else
      FILL: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // hit pipeline, fetch address/data latches, valid bits and victim pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid     <= '0;
      victim    <= '0;
      word_addr <= '0;
      fill_data <= '0;
      data_q    <= '0;
      hit_q     <= 1'b0;
      last_addr <= '0;
`ifdef JT6295_PREFETCH_EN
      pf        <= 1'b0;
`endif
    end else begin
      hit_q     <= hit;
      last_addr <= bus.rom_addr;
      if (hit) data_q <= hit_word[{bus.rom_addr[1:0], 3'b000} +: 8];
      if (state == IDLE && !hit) word_addr <= bus.rom_addr[17:2];
      if (capture) fill_data <= bus.sdram_data;
      if (state == FILL) begin
        valid[victim] <= 1'b1;
        victim        <= victim + VW'(1);
      end
`ifdef JT6295_PREFETCH_EN
      if (state == FILL) pf <= 1'b0;
      if (state == PREFETCH) begin
        pf <= !pf_hit;
        if (!pf_hit) word_addr <= word_addr + 16'd1;
      end
`endif
    end
  // line storage needs no reset: valid bits gate every use
  always_ff @(posedge clk)
    if (state == FILL) begin
      tag[victim]  <= word_addr;
      line[victim] <= fill_data;
    end
  assign bus.rom_data   = data_q;
  assign bus.rom_ok     = hit_q && last_addr == bus.rom_addr;
  assign bus.sdram_addr = word_addr;
  assign bus.sdram_req  = state == REQ;
endmodule

// File: tb/tb_jt6295_romcache.sv
// tb_jt6295_romcache: scoreboard bench for the jt6295 ROM cache (LINES=4)
module tb_jt6295_romcache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  jt6295_romcache_if bus ();
  jt6295_romcache #(.LINES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] data_of(input logic [15:0] w);
    return {w[7:0] ^ 8'h5A, w[15:8], ~w[7:0], w[15:8] ^ 8'hA5};
  endfunction
  function automatic logic [7:0] byte_of(input logic [17:0] a);
    logic [31:0] d;
    d = data_of(a[17:2]);
    return d[8*a[1:0] +: 8];
  endfunction
  function automatic logic [7:0] pop_exp();
    return exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
  endfunction
  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!bus.sdram_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.sdram_req) cyc = -1;
  endtask
  task automatic wait_ok(output int cyc);
    cyc = 0;
    while (!bus.rom_ok && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.rom_ok) cyc = -1;
  endtask
  task automatic respond(input logic [31:0] d, input bit split);
    bus.sdram_ack = 1'b1;
    bus.sdram_dok = !split;
    bus.sdram_data = d;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.sdram_dok = 1'b0;
    if (split) begin
      @(negedge clk);
      bus.sdram_dok = 1'b1;
      @(negedge clk);
      bus.sdram_dok = 1'b0;
    end
  endtask
  task automatic fetch(input logic [17:0] a, input bit split, input string nm);
    int cyc;
    logic [7:0] e;
    bus.rom_addr = a;
    exp_q.push_back(byte_of(a));
    wait_req(cyc);
    checks++;
    if (cyc < 0) begin fails++; $display("FAIL %s_req: no sdram_req for addr %h", nm, a); end
    checks++;
    if (bus.sdram_addr !== a[17:2]) begin fails++; $display("FAIL %s_sdram_addr: got %h want %h", nm, bus.sdram_addr, a[17:2]); end
    respond(data_of(a[17:2]), split);
    wait_ok(cyc);
    e = pop_exp();
    checks++;
    if (cyc < 0) begin fails++; $display("FAIL %s_ok: rom_ok never rose for addr %h", nm, a); end
    checks++;
    if (bus.rom_data !== e) begin fails++; $display("FAIL %s_data: got %h want %h", nm, bus.rom_data, e); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.rom_addr = 18'h00005;
    bus.sdram_ack = 1'b0;
    bus.sdram_dok = 1'b0;
    bus.sdram_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rom_data !== 8'h00) begin fails++; $display("FAIL reset_rom_data: got %h want 00", bus.rom_data); end
    checks++;
    if (bus.rom_ok !== 1'b0) begin fails++; $display("FAIL reset_rom_ok: got %b want 0", bus.rom_ok); end
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL reset_sdram_req: got %b want 0", bus.sdram_req); end
    checks++;
    if (bus.sdram_addr !== 16'h0000) begin fails++; $display("FAIL reset_sdram_addr: got %h want 0000", bus.sdram_addr); end
  endtask
  task automatic test_first_fill();
    int cyc;
    logic [7:0] e;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sdram_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", bus.sdram_req); end
    checks++;
    if (bus.sdram_addr !== 16'h0001) begin fails++; $display("FAIL first_sdram_addr: got %h want 0001", bus.sdram_addr); end
    exp_q.push_back(8'h22);
    respond(32'h44332211, 1'b0);
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL first_req_drop: got %b want 0", bus.sdram_req); end
    cyc = 1;
    while (!bus.rom_ok && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 3) begin fails++; $display("FAIL first_latency: got %0d want 3 clocks", cyc); end
    e = pop_exp();
    checks++;
    if (bus.rom_data !== e) begin fails++; $display("FAIL first_data: got %h want %h", bus.rom_data, e); end
  endtask
  task automatic test_byte_walk();
    logic [31:0] w;
    logic [7:0] e;
    w = 32'h44332211;
    for (int i = 4; i < 8; i++) begin
      bus.rom_addr = 18'(i);
      exp_q.push_back(w[8*(i-4) +: 8]);
      @(negedge clk);
      e = pop_exp();
      checks++;
      if (bus.rom_ok !== 1'b1) begin fails++; $display("FAIL walk_ok[%0d]: got %b want 1", i, bus.rom_ok); end
      checks++;
      if (bus.rom_data !== e) begin fails++; $display("FAIL walk_data[%0d]: got %h want %h", i, bus.rom_data, e); end
      checks++;
      if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL walk_req[%0d]: got %b want 0", i, bus.sdram_req); end
    end
  endtask
  task automatic test_eviction();
    int cyc;
    logic [7:0] e;
    for (int i = 0; i < 5; i++) fetch({16'h0100 + 16'(i), 2'b01}, i[0], "evict_fill");
    bus.rom_addr = {16'h0101, 2'b11};
    exp_q.push_back(byte_of({16'h0101, 2'b11}));
    @(negedge clk);
    e = pop_exp();
    checks++;
    if (bus.rom_ok !== 1'b1) begin fails++; $display("FAIL evict_second_ok: got %b want 1", bus.rom_ok); end
    checks++;
    if (bus.rom_data !== e) begin fails++; $display("FAIL evict_second_data: got %h want %h", bus.rom_data, e); end
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL evict_second_req: got %b want 0", bus.sdram_req); end
    bus.rom_addr = {16'h0100, 2'b00};
    exp_q.push_back(byte_of({16'h0100, 2'b00}));
    @(negedge clk);
    checks++;
    if (bus.sdram_req !== 1'b1) begin fails++; $display("FAIL evict_first_miss: got req %b want 1", bus.sdram_req); end
    checks++;
    if (bus.sdram_addr !== 16'h0100) begin fails++; $display("FAIL evict_first_addr: got %h want 0100", bus.sdram_addr); end
    respond(data_of(16'h0100), 1'b1);
    wait_ok(cyc);
    e = pop_exp();
    checks++;
    if (cyc < 0 || bus.rom_data !== e) begin fails++; $display("FAIL evict_refill_data: got %h ok %b want %h", bus.rom_data, bus.rom_ok, e); end
  endtask
  task automatic test_addr_change();
    int cyc;
    logic [7:0] e;
    bus.rom_addr = 18'h00010;
    wait_req(cyc);
    checks++;
    if (cyc < 0 || bus.sdram_addr !== 16'h0004) begin fails++; $display("FAIL move_req: got addr %h cyc %0d want 0004", bus.sdram_addr, cyc); end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.rom_addr = 18'h00100;
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL move_wait_req: got %b want 0", bus.sdram_req); end
    @(negedge clk);
    checks++;
    if (bus.rom_ok !== 1'b0) begin fails++; $display("FAIL move_wait_ok: got %b want 0", bus.rom_ok); end
    checks++;
    if (bus.sdram_addr !== 16'h0004) begin fails++; $display("FAIL move_addr_stable: got %h want 0004", bus.sdram_addr); end
    bus.sdram_dok = 1'b1;
    bus.sdram_data = data_of(16'h0004);
    @(negedge clk);
    bus.sdram_dok = 1'b0;
    exp_q.push_back(byte_of(18'h00100));
    wait_req(cyc);
    checks++;
    if (cyc < 0 || bus.sdram_addr !== 16'h0040) begin fails++; $display("FAIL move_new_req: got addr %h cyc %0d want 0040", bus.sdram_addr, cyc); end
    checks++;
    if (bus.rom_ok !== 1'b0) begin fails++; $display("FAIL move_ok_low: got %b want 0", bus.rom_ok); end
    respond(data_of(16'h0040), 1'b0);
    wait_ok(cyc);
    e = pop_exp();
    checks++;
    if (cyc < 0 || bus.rom_data !== e) begin fails++; $display("FAIL move_new_data: got %h ok %b want %h", bus.rom_data, bus.rom_ok, e); end
    bus.rom_addr = 18'h00012;
    exp_q.push_back(byte_of(18'h00012));
    @(negedge clk);
    e = pop_exp();
    checks++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== e) begin fails++; $display("FAIL move_old_word: got %h ok %b want %h ok 1", bus.rom_data, bus.rom_ok, e); end
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL move_old_req: got %b want 0", bus.sdram_req); end
  endtask
  task automatic test_reset_mid_fill();
    int cyc;
    logic [7:0] e;
    bus.rom_addr = 18'h00200;
    wait_req(cyc);
    checks++;
    if (cyc < 0 || bus.sdram_addr !== 16'h0080) begin fails++; $display("FAIL rst_fill_req: got addr %h cyc %0d want 0080", bus.sdram_addr, cyc); end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rom_ok !== 1'b0 || bus.rom_data !== 8'h00) begin fails++; $display("FAIL rst_fill_outputs: got data %h ok %b want 00 0", bus.rom_data, bus.rom_ok); end
    checks++;
    if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 16'h0000) begin fails++; $display("FAIL rst_fill_sdram: got req %b addr %h want 0 0000", bus.sdram_req, bus.sdram_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.sdram_dok = 1'b1;
    bus.sdram_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.sdram_dok = 1'b0;
    checks++;
    if (bus.rom_ok !== 1'b0) begin fails++; $display("FAIL rst_late_dok_ok: got %b want 0", bus.rom_ok); end
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 16'h0080) begin fails++; $display("FAIL rst_late_dok_refetch: got req %b addr %h want 1 0080", bus.sdram_req, bus.sdram_addr); end
    exp_q.push_back(byte_of(18'h00200));
    respond(data_of(16'h0080), 1'b1);
    wait_ok(cyc);
    e = pop_exp();
    checks++;
    if (cyc < 0 || bus.rom_data !== e) begin fails++; $display("FAIL rst_refetch_data: got %h ok %b want %h", bus.rom_data, bus.rom_ok, e); end
    bus.rom_addr = 18'h00012;
    @(negedge clk);
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.rom_ok !== 1'b0) begin fails++; $display("FAIL rst_cleared_line: got req %b ok %b want 1 0", bus.sdram_req, bus.rom_ok); end
    fetch(18'h00012, 1'b0, "rst_after");
  endtask
`ifdef JT6295_PREFETCH_EN
  task automatic test_prefetch();
    int cyc;
    logic [7:0] e;
    bus.rom_addr = 18'h3FFFC;
    rst_n = 1'b1;
    fetch(18'h3FFFC, 1'b0, "pf_demand");
    wait_req(cyc);
    checks++;
    if (cyc < 0 || bus.sdram_addr !== 16'h0000) begin fails++; $display("FAIL pf_next_req: got addr %h cyc %0d want 0000", bus.sdram_addr, cyc); end
    respond(data_of(16'h0000), 1'b0);
    bus.rom_addr = 18'h00002;
    exp_q.push_back(byte_of(18'h00002));
    wait_ok(cyc);
    e = pop_exp();
    checks++;
    if (cyc < 0 || bus.rom_data !== e) begin fails++; $display("FAIL pf_hit_data: got %h ok %b want %h", bus.rom_data, bus.rom_ok, e); end
    checks++;
    if (bus.sdram_req !== 1'b0) begin fails++; $display("FAIL pf_hit_req: got %b want 0", bus.sdram_req); end
  endtask
`endif
  initial begin
    test_reset();
`ifdef JT6295_PREFETCH_EN
    test_prefetch();
`else
    test_first_fill();
    test_byte_walk();
    test_eviction();
    test_addr_change();
    test_reset_mid_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
